pipe_stage_skid: RTL and testbench
==================================

# pipe_stage_skid

Parametrised pipeline-stage register for the RV32I core. It is the successor to the fixed MEM→WB latch. It carries PC, instruction, destination register and its value, plus a generic sideband field, across one stage boundary using a valid/ready handshake. It adds an optional two-entry skid buffer, synchronous flush, and a youngest-first register-value lookup port for the hazard/forwarding unit.

## Interface
- XLEN, 32: width of PC, INST and REG_D_V.
- REG_AW, 5: register-address width.
- SIDE_W, 1: opaque sideband width (≥1), passed through unchanged.
- SKID, 1: 1 = two entries with a registered A_READY; 0 = one entry with a combinational A_READY.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-low.
- FLUSH  in  1  synchronous discard of all held entries.
- A_VALID  in  1  upstream entry valid.
- A_READY  out  1  stage can accept.
- A_PC, A_INST, A_REG_D_V  in  XLEN  upstream payload.
- A_REG_D  in  REG_AW  destination register; 0 means no write.
- A_SIDE  in  SIDE_W  sideband.
- M_VALID  out  1  downstream entry valid.
- M_READY  in  1  downstream accepts.
- M_PC, M_INST, M_REG_D, M_REG_D_V, M_SIDE  out  as A_*  main-entry payload.
- Q_REG  in  REG_AW  lookup address.
- Q_HIT  out  1  a held valid entry writes Q_REG, and Q_REG ≠ 0.
- Q_V  out  XLEN  value from the youngest matching entry; 0 when Q_HIT=0.

## Operation
- Accept = A_VALID & A_READY. Retire = M_VALID & M_READY.
- The main entry drives the M_* outputs. The skid entry (SKID=1 only) holds the younger of the two entries.
- States for SKID=1:
  - EMPTY: accept → ONE.
  - ONE: accept & retire → ONE, with main reloaded. Accept & ~retire → TWO, with the new entry into skid. ~accept & retire → EMPTY.
  - TWO: retire → ONE, with skid moved to main. A_READY=0 in TWO.
- A_READY is registered when SKID=1: it is 1 in the cycle after the state is EMPTY or ONE, and 0 in TWO.
- When SKID=0: A_READY = ~M_VALID | M_READY. The stage holds one entry and has no TWO state.
- FLUSH has priority over accept and retire.
  - Next edge: all valid bits clear, and any input accepted in the flush cycle is dropped.
  - The cycle after the flush edge: A_READY=1.
- Payload registers load only on the edge where they capture an entry. They are not cleared on retire or flush, so consumers must qualify with M_VALID.
- Lookup is combinational.
  - The skid entry, if valid, is checked before the main entry.
  - Q_REG=0 never hits.
  - Flushed or retired entries never hit.

## Timing
- Reset (RST=0, asynchronous): M_VALID=0, all M_* payloads 0, Q_HIT=0, Q_V=0, state EMPTY, A_READY=1.
- Latency: an entry accepted at edge N appears on M_* after edge N when the stage is EMPTY or retiring. Otherwise it follows the older entry.
- Throughput is 1 entry/cycle with M_READY held high, for both SKID values.
- M_* outputs are stable while M_VALID=1 & M_READY=0.
- Upstream must hold A_* while A_VALID=1 & A_READY=0.
- Reset deasserting mid-transfer: no entry survives, and the first accept is allowed on the first edge after release.
- Q_HIT/Q_V reflect the register state after the latest edge, with no extra cycle of delay.

## Structure
- Shared package cpu_pipe_pkg: XLEN/REG_AW defaults, state encoding (EMPTY/ONE/TWO), and a zero-register constant.
- One sub-module, pipe_slot: a single entry with valid bit, payload registers, load enable and clear. It is instantiated twice when SKID=1 and once when SKID=0.
- This block owns the state machine, A_READY generation and lookup priority.

## Test plan
- Reset, then stream PC 0x00,0x04,0x08 with M_READY=1 → each appears one cycle later; A_READY stays 1; no bubbles.
- SKID=1: accept 0x10, drop M_READY, accept 0x14 → state TWO, A_READY=0 next cycle, M_PC=0x10. Raise M_READY → 0x10, then 0x14 retire in order; 0x18 is held upstream until A_READY returns.
- FLUSH while in TWO with A_VALID=1 → M_VALID=0 after the edge; the offered entry is dropped; A_READY=1 the next cycle.
- Main holds REG_D=5 / 0x11, skid holds REG_D=5 / 0x22, Q_REG=5 → Q_HIT=1, Q_V=0x22. With Q_REG=0 and REG_D=0 → Q_HIT=0, Q_V=0.
- SKID=0, M_READY=0 with an entry held → A_READY=0 combinationally; raising M_READY gives A_READY=1 in the same cycle.
- Assert RST while in TWO → all outputs return to reset values immediately (before the next edge); A_READY=1.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// rtl/cpu_pipe_pkg.sv - shared widths, stage state encoding and zero-register constant
package cpu_pipe_pkg;
  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;
  localparam int ZERO_REG   = 0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_t;
endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - single pipeline entry: valid bit plus payload register
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] data_in,
  output logic         valid,
  output logic [W-1:0] data
);
  // Payload only moves on load so downstream values stay put while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      if (clear)     valid <= 1'b0;
      else if (load) valid <= 1'b1;
      if (load) data <= data_in;
    end
  end
endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - valid/ready pipeline stage with optional skid entry, flush and lookup
module pipe_stage_skid
  import cpu_pipe_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int SIDE_W = 1,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [XLEN-1:0]   a_pc,
  input  logic [XLEN-1:0]   a_inst,
  input  logic [REG_AW-1:0] a_reg_d,
  input  logic [XLEN-1:0]   a_reg_d_v,
  input  logic [SIDE_W-1:0] a_side,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [XLEN-1:0]   m_pc,
  output logic [XLEN-1:0]   m_inst,
  output logic [REG_AW-1:0] m_reg_d,
  output logic [XLEN-1:0]   m_reg_d_v,
  output logic [SIDE_W-1:0] m_side,
  input  logic [REG_AW-1:0] q_reg,
  output logic              q_hit,
  output logic [XLEN-1:0]   q_v
);
  localparam int PW = 3*XLEN + REG_AW + SIDE_W;

  stage_state_t    state, state_n;
  logic            a_ready_q;
  logic            accept, retire;
  logic            main_load, main_clear, main_from_skid, skid_load, skid_clear;
  logic            main_valid, skid_valid;
  logic [PW-1:0]   a_data, main_in, main_data, skid_data;
  logic [REG_AW-1:0] skid_reg_d;
  logic [XLEN-1:0] skid_reg_d_v;

  assign a_data  = {a_pc, a_inst, a_reg_d, a_reg_d_v, a_side};
  assign {m_pc, m_inst, m_reg_d, m_reg_d_v, m_side} = main_data;
  assign m_valid = main_valid;
  assign accept  = a_valid & a_ready;
  assign retire  = main_valid & m_ready;
  assign main_in = main_from_skid ? skid_data : a_data;
  assign skid_reg_d   = skid_data[SIDE_W+XLEN +: REG_AW];
  assign skid_reg_d_v = skid_data[SIDE_W +: XLEN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      a_ready_q <= 1'b1;
    end else begin
      state     <= state_n;
      a_ready_q <= (state_n != ST_TWO);
    end
  end

  // With SKID=0 the combinational ready makes accept imply retire in ONE, so TWO is unreachable.
  always_comb begin
    state_n        = state;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      state_n    = ST_EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state)
        ST_EMPTY: if (accept) begin
          main_load = 1'b1;
          state_n   = ST_ONE;
        end
        ST_ONE: begin
          if (accept && retire) begin
            main_load = 1'b1;
          end else if (accept) begin
            skid_load = 1'b1;
            state_n   = ST_TWO;
          end else if (retire) begin
            main_clear = 1'b1;
            state_n    = ST_EMPTY;
          end
        end
        ST_TWO: if (retire) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          skid_clear     = 1'b1;
          state_n        = ST_ONE;
        end
        default: state_n = ST_EMPTY;
      endcase
    end
  end

  pipe_slot #(.W(PW)) u_main (
    .clk(clk), .rst_n(rst_n), .load(main_load), .clear(main_clear),
    .data_in(main_in), .valid(main_valid), .data(main_data)
  );

  if (SKID != 0) begin : g_skid
    pipe_slot #(.W(PW)) u_skid (
      .clk(clk), .rst_n(rst_n), .load(skid_load), .clear(skid_clear),
      .data_in(a_data), .valid(skid_valid), .data(skid_data)
    );
    assign a_ready = a_ready_q;
  end else begin : g_noskid
    assign skid_valid = 1'b0;
    assign skid_data  = '0;
    assign a_ready    = ~main_valid | m_ready;
  end

  // Skid holds the younger entry, so it wins the forwarding lookup.
  always_comb begin
    q_hit = 1'b0;
    q_v   = '0;
    if (q_reg != REG_AW'(ZERO_REG)) begin
      if (skid_valid && skid_reg_d == q_reg) begin
        q_hit = 1'b1;
        q_v   = skid_reg_d_v;
      end else if (main_valid && m_reg_d == q_reg) begin
        q_hit = 1'b1;
        q_v   = m_reg_d_v;
      end
    end
  end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - SKID=0 and SKID=1 stages against a queue reference model
module tb_pipe_stage_skid;
  localparam int XLEN = 32, REG_AW = 5, SIDE_W = 3;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   inst;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   rv;
    logic [SIDE_W-1:0] side;
  } ent_t;

  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, a_valid = 1'b0, m_ready = 1'b0;
  ent_t a = '0;
  logic [REG_AW-1:0] q_reg = '0;
  logic              a_ready[2], m_valid[2], q_hit[2];
  logic [XLEN-1:0]   m_pc[2], m_inst[2], m_reg_d_v[2], q_v[2];
  logic [REG_AW-1:0] m_reg_d[2];
  logic [SIDE_W-1:0] m_side[2];

  int n_vec = 0, n_err = 0;
  bit last_acc1 = 0;
  ent_t mq[2][$];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    pipe_stage_skid #(.XLEN(XLEN), .REG_AW(REG_AW), .SIDE_W(SIDE_W), .SKID(k)) u_dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .a_valid(a_valid), .a_ready(a_ready[k]),
      .a_pc(a.pc), .a_inst(a.inst), .a_reg_d(a.rd), .a_reg_d_v(a.rv), .a_side(a.side),
      .m_valid(m_valid[k]), .m_ready(m_ready), .m_pc(m_pc[k]), .m_inst(m_inst[k]),
      .m_reg_d(m_reg_d[k]), .m_reg_d_v(m_reg_d_v[k]), .m_side(m_side[k]),
      .q_reg(q_reg), .q_hit(q_hit[k]), .q_v(q_v[k])
    );
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_ready(input int k);
    if (k == 1) return mq[1].size() < 2;
    return (mq[0].size() == 0) || m_ready;
  endfunction

  function automatic ent_t rnd_ent();
    ent_t e;
    e.pc   = $urandom;
    e.inst = $urandom;
    e.rd   = REG_AW'($urandom_range(0, 3));
    e.rv   = $urandom;
    e.side = SIDE_W'($urandom);
    return e;
  endfunction

  function automatic ent_t mk(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] rv);
    ent_t e;
    e = rnd_ent();
    e.pc = pc; e.rd = rd; e.rv = rv;
    return e;
  endfunction

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      bit hit;
      logic [XLEN-1:0] v;
      hit = 0; v = '0;
      check($sformatf("a_ready%0d", k), a_ready[k], exp_ready(k));
      check($sformatf("m_valid%0d", k), m_valid[k], mq[k].size() != 0);
      if (mq[k].size() != 0)
        check($sformatf("m_data%0d", k),
              {m_pc[k], m_inst[k], m_reg_d[k], m_reg_d_v[k], m_side[k]}, mq[k][0]);
      // later queue entries are younger, so the last match wins
      if (q_reg != 0)
        for (int i = 0; i < mq[k].size(); i++)
          if (mq[k][i].rd == q_reg) begin hit = 1; v = mq[k][i].rv; end
      check($sformatf("q_hit%0d", k), q_hit[k], hit);
      check($sformatf("q_v%0d", k), q_v[k], v);
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      bit acc, ret;
      acc = a_valid && exp_ready(k);
      ret = (mq[k].size() != 0) && m_ready;
      if (k == 1) last_acc1 = acc && !flush;
      if (flush) mq[k].delete();
      else begin
        if (ret) void'(mq[k].pop_front());
        if (acc) mq[k].push_back(a);
      end
    end
  endtask

  task automatic step(input bit av, input ent_t ap, input bit mr, input bit fl,
                      input logic [REG_AW-1:0] qr);
    a_valid = av; a = ap; m_ready = mr; flush = fl; q_reg = qr;
    #1 compare_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic reset_checks(input string tag);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("%s_m_valid%0d", tag, k), m_valid[k], 1'b0);
      check($sformatf("%s_a_ready%0d", tag, k), a_ready[k], 1'b1);
      check($sformatf("%s_q_hit%0d", tag, k), q_hit[k], 1'b0);
      check($sformatf("%s_q_v%0d", tag, k), q_v[k], '0);
      check($sformatf("%s_m_data%0d", tag, k),
            {m_pc[k], m_inst[k], m_reg_d[k], m_reg_d_v[k], m_side[k]}, '0);
    end
  endtask

  initial begin
    ent_t e;
    q_reg = 5'd1;
    @(negedge clk); @(negedge clk);
    #1 reset_checks("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // streaming with M_READY high
    step(1, mk(32'h00, 1, 32'hA0), 1, 0, 1);
    step(1, mk(32'h04, 2, 32'hA4), 1, 0, 1);
    step(1, mk(32'h08, 3, 32'hA8), 1, 0, 2);
    step(0, mk(32'h0C, 0, 0), 1, 0, 3);
    step(0, mk(32'h0C, 0, 0), 1, 0, 0);

    // fill to TWO, hold 0x18 upstream, then drain in order
    step(1, mk(32'h10, 1, 1), 0, 0, 0);
    step(1, mk(32'h14, 2, 2), 0, 0, 0);
    e = mk(32'h18, 3, 3);
    step(1, e, 0, 0, 0);
    step(1, e, 1, 0, 0);
    step(1, e, 1, 0, 0);
    step(1, e, 1, 0, 0);
    step(0, e, 1, 0, 0);
    step(0, e, 1, 0, 0);

    // flush while in TWO with an entry on offer
    step(1, mk(32'h30, 4, 4), 0, 0, 4);
    step(1, mk(32'h34, 4, 5), 0, 0, 4);
    step(1, mk(32'h38, 4, 6), 0, 1, 4);
    step(0, mk(32'h3C, 4, 7), 0, 0, 4);

    // youngest-first lookup, zero register never hits
    step(1, mk(32'h40, 5, 32'h11), 0, 0, 5);
    step(1, mk(32'h44, 5, 32'h22), 0, 0, 5);
    step(0, mk(32'h48, 0, 0), 0, 0, 5);
    step(0, mk(32'h48, 0, 0), 1, 1, 0);
    step(1, mk(32'h50, 0, 32'h33), 0, 0, 0);
    step(1, mk(32'h54, 0, 32'h44), 0, 0, 0);
    step(0, mk(32'h58, 0, 0), 0, 0, 0);
    step(0, mk(32'h58, 0, 0), 1, 0, 0);
    step(0, mk(32'h58, 0, 0), 1, 1, 0);

    // asynchronous reset while in TWO
    step(1, mk(32'h60, 6, 32'h66), 0, 0, 6);
    step(1, mk(32'h64, 6, 32'h77), 0, 0, 6);
    a_valid = 0; #2 rst_n = 1'b0;
    #1 reset_checks("async_rst");
    mq[0].delete(); mq[1].delete();
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    step(1, mk(32'h70, 7, 32'h88), 0, 0, 7);
    step(0, mk(32'h74, 0, 0), 1, 0, 7);

    // randomized traffic; upstream holds its payload until the skid stage takes it
    e = rnd_ent();
    for (int i = 0; i < 1500; i++) begin
      bit av, hold;
      hold = a_valid && !last_acc1 && !flush;
      av = hold ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (!hold) e = rnd_ent();
      step(av, e, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
           REG_AW'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
